// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-enable divider, position counters,
// registered sync/blank decodes, line/frame strobes and a look-ahead fetch position.
module vga_timing_gen #(
  parameter int H_DISP       = 640,
  parameter int H_FP         = 16,
  parameter int H_PW         = 96,
  parameter int H_BP         = 48,
  parameter int V_DISP       = 480,
  parameter int V_FP         = 10,
  parameter int V_PW         = 2,
  parameter int V_BP         = 29,
  parameter int H_POL        = 0,
  parameter int V_POL        = 0,
  parameter int CLK_DIV      = 2,
  parameter int LOOKAHEAD    = 2,
  parameter int COUNTER_BITS = 10
) (
  input  logic                    clk_50MHz,
  input  logic                    clear,
  output logic                    pix_en,
  output logic [COUNTER_BITS-1:0] h_count,
  output logic [COUNTER_BITS-1:0] v_count,
  output logic                    h_sync,
  output logic                    v_sync,
  output logic                    bright,
  output logic                    line_start,
  output logic                    frame_start,
  output logic                    vblank_start,
  output logic [7:0]              frame_count,
  output logic [COUNTER_BITS-1:0] fetch_x,
  output logic [COUNTER_BITS-1:0] fetch_y,
  output logic                    fetch_valid
);

  localparam int H_TOTAL  = H_DISP + H_FP + H_PW + H_BP;
  localparam int V_TOTAL  = V_DISP + V_FP + V_PW + V_BP;
  localparam int DIV_BITS = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW       = COUNTER_BITS + 1;

  localparam logic [DIV_BITS-1:0]     DIV_LAST = DIV_BITS'(CLK_DIV - 1);
  localparam logic [COUNTER_BITS-1:0] H_LAST   = COUNTER_BITS'(H_TOTAL - 1);
  localparam logic [COUNTER_BITS-1:0] V_LAST   = COUNTER_BITS'(V_TOTAL - 1);
  localparam logic [COUNTER_BITS-1:0] FX_RST   = COUNTER_BITS'(LOOKAHEAD);

  // One extra bit so a window edge equal to 2^COUNTER_BITS still compares correctly
  localparam logic [CW-1:0] H_DISP_W = CW'(H_DISP);
  localparam logic [CW-1:0] HS_ON_W  = CW'(H_DISP + H_FP);
  localparam logic [CW-1:0] HS_OFF_W = CW'(H_DISP + H_FP + H_PW);
  localparam logic [CW-1:0] V_DISP_W = CW'(V_DISP);
  localparam logic [CW-1:0] VS_ON_W  = CW'(V_DISP + V_FP);
  localparam logic [CW-1:0] VS_OFF_W = CW'(V_DISP + V_FP + V_PW);

  localparam logic H_ACT  = (H_POL != 0);
  localparam logic V_ACT  = (V_POL != 0);
  localparam logic FV_RST = (LOOKAHEAD < H_DISP) && (V_DISP > 0);

  logic [DIV_BITS-1:0]     r_div_cnt;
  logic [COUNTER_BITS-1:0] r_h_count;
  logic [COUNTER_BITS-1:0] r_v_count;
  logic [COUNTER_BITS-1:0] r_fetch_x;
  logic [COUNTER_BITS-1:0] r_fetch_y;
  logic [7:0]              r_frame_count;
  logic                    r_h_sync;
  logic                    r_v_sync;
  logic                    r_bright;
  logic                    r_fetch_valid;

  logic                    w_adv;
  logic                    w_h_wrap;
  logic                    w_frame_wrap;
  logic                    w_fx_wrap;
  logic [COUNTER_BITS-1:0] w_h_next;
  logic [COUNTER_BITS-1:0] w_v_next;
  logic [COUNTER_BITS-1:0] w_fx_next;
  logic [COUNTER_BITS-1:0] w_fy_next;
  logic [CW-1:0]           w_h_ext;
  logic [CW-1:0]           w_v_ext;
  logic [CW-1:0]           w_fx_ext;
  logic [CW-1:0]           w_fy_ext;
  logic                    w_bright_next;
  logic                    w_hs_next;
  logic                    w_vs_next;
  logic                    w_fv_next;

  always_comb begin
    w_adv        = (r_div_cnt == DIV_LAST);
    w_h_wrap     = (r_h_count == H_LAST);
    w_frame_wrap = w_h_wrap && (r_v_count == V_LAST);
    w_h_next     = w_h_wrap ? '0 : r_h_count + 1'b1;
    w_v_next     = r_v_count;
    if (w_h_wrap) begin
      w_v_next = (r_v_count == V_LAST) ? '0 : r_v_count + 1'b1;
    end

    w_fx_wrap = (r_fetch_x == H_LAST);
    w_fx_next = w_fx_wrap ? '0 : r_fetch_x + 1'b1;
    w_fy_next = r_fetch_y;
    if (w_fx_wrap) begin
      w_fy_next = (r_fetch_y == V_LAST) ? '0 : r_fetch_y + 1'b1;
    end

    w_h_ext  = {1'b0, w_h_next};
    w_v_ext  = {1'b0, w_v_next};
    w_fx_ext = {1'b0, w_fx_next};
    w_fy_ext = {1'b0, w_fy_next};

    // Decodes of the position being entered, so the registered outputs line up with it
    w_bright_next = (w_h_ext < H_DISP_W) && (w_v_ext < V_DISP_W);
    w_hs_next     = (w_h_ext >= HS_ON_W) && (w_h_ext < HS_OFF_W);
    w_vs_next     = (w_v_ext >= VS_ON_W) && (w_v_ext < VS_OFF_W);
    w_fv_next     = (w_fx_ext < H_DISP_W) && (w_fy_ext < V_DISP_W);
  end

  always_ff @(posedge clk_50MHz or negedge clear) begin
    if (!clear) begin
      r_div_cnt     <= '0;
      r_h_count     <= '0;
      r_v_count     <= '0;
      r_fetch_x     <= FX_RST;
      r_fetch_y     <= '0;
      r_frame_count <= '0;
      r_h_sync      <= ~H_ACT;
      r_v_sync      <= ~V_ACT;
      r_bright      <= 1'b1;
      r_fetch_valid <= FV_RST;
    end else begin
      r_div_cnt <= w_adv ? '0 : r_div_cnt + 1'b1;
      if (w_adv) begin
        r_h_count     <= w_h_next;
        r_v_count     <= w_v_next;
        r_fetch_x     <= w_fx_next;
        r_fetch_y     <= w_fy_next;
        r_bright      <= w_bright_next;
        r_h_sync      <= w_hs_next ? H_ACT : ~H_ACT;
        r_v_sync      <= w_vs_next ? V_ACT : ~V_ACT;
        r_fetch_valid <= w_fv_next;
        if (w_frame_wrap) begin
          r_frame_count <= r_frame_count + 8'd1;
        end
      end
    end
  end

  // Strobes are qualified by pix_en so they last one clk, not a whole pixel period
  assign pix_en       = (r_div_cnt == '0);
  assign line_start   = pix_en && (r_h_count == '0);
  assign frame_start  = line_start && (r_v_count == '0);
  assign vblank_start = line_start && ({1'b0, r_v_count} == V_DISP_W);

  assign h_count     = r_h_count;
  assign v_count     = r_v_count;
  assign h_sync      = r_h_sync;
  assign v_sync      = r_v_sync;
  assign bright      = r_bright;
  assign frame_count = r_frame_count;
  assign fetch_x     = r_fetch_x;
  assign fetch_y     = r_fetch_y;
  assign fetch_valid = r_fetch_valid;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance plus a tiny 8x4 instance (CLK_DIV=1,
// positive syncs) so whole frames fit in a short run.
module tb_vga_timing_gen;

  logic clk;
  logic clear_a;
  logic clear_b;

  logic       a_pix_en, a_hs, a_vs, a_bright, a_ls, a_fs, a_vb, a_fv;
  logic [9:0] a_h, a_v, a_fx, a_fy;
  logic [7:0] a_fc;

  logic       b_pix_en, b_hs, b_vs, b_bright, b_ls, b_fs, b_vb, b_fv;
  logic [3:0] b_h, b_v, b_fx, b_fy;
  logic [7:0] b_fc;

  int n_pass;
  int n_total;

  vga_timing_gen u_a (
    .clk_50MHz(clk), .clear(clear_a), .pix_en(a_pix_en), .h_count(a_h), .v_count(a_v),
    .h_sync(a_hs), .v_sync(a_vs), .bright(a_bright), .line_start(a_ls),
    .frame_start(a_fs), .vblank_start(a_vb), .frame_count(a_fc),
    .fetch_x(a_fx), .fetch_y(a_fy), .fetch_valid(a_fv)
  );

  vga_timing_gen #(
    .H_DISP(8), .H_FP(1), .H_PW(2), .H_BP(1),
    .V_DISP(4), .V_FP(1), .V_PW(1), .V_BP(1),
    .H_POL(1), .V_POL(1), .CLK_DIV(1), .LOOKAHEAD(2), .COUNTER_BITS(4)
  ) u_b (
    .clk_50MHz(clk), .clear(clear_b), .pix_en(b_pix_en), .h_count(b_h), .v_count(b_v),
    .h_sync(b_hs), .v_sync(b_vs), .bright(b_bright), .line_start(b_ls),
    .frame_start(b_fs), .vblank_start(b_vb), .frame_count(b_fc),
    .fetch_x(b_fx), .fetch_y(b_fy), .fetch_valid(b_fv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to the first clk of pixel (hh,vv) on instance A
  task automatic wait_a(input int hh, input int vv, input int budget, output logic found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (a_pix_en && int'(a_h) == hh && int'(a_v) == vv) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  logic found;
  int   cyc, hmax, br_clk, br_first, br_last, hs_clk, hs_first, hs_last;
  int   b_pe0, b_hs_n, b_hs_min, b_hs_max, b_vs_n, b_vs_min, b_vs_max;
  int   b_fs_n, b_fs_idx, b_vb_n, b_vb_v, b_ls_n, b_fc_84;
  int   b_f10_x, b_f10_y, b_f10_v, b_f11_x, b_f11_y, b_br_7, b_br_8;

  initial begin
    n_pass  = 0;
    n_total = 0;
    clear_a = 1'b1;
    clear_b = 1'b1;
    #2;
    clear_a = 1'b0;
    clear_b = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_pix_en", a_pix_en, 1);
    chk("rst_h", a_h, 0);
    chk("rst_v", a_v, 0);
    chk("rst_bright", a_bright, 1);
    chk("rst_hsync", a_hs, 1);
    chk("rst_vsync", a_vs, 1);
    chk("rst_line_start", a_ls, 1);
    chk("rst_frame_start", a_fs, 1);
    chk("rst_vblank_start", a_vb, 0);
    chk("rst_frame_count", a_fc, 0);
    chk("rst_fetch_x", a_fx, 2);
    chk("rst_fetch_y", a_fy, 0);
    chk("rst_fetch_valid", a_fv, 1);
    chk("rst_b_hsync", b_hs, 0);
    chk("rst_b_vsync", b_vs, 0);

    // Release: pix_en pattern 1,0,1,0
    clear_a = 1'b1;
    clear_b = 1'b1;
    chk("pix_en_0", a_pix_en, 1);
    @(negedge clk);
    chk("pix_en_1", a_pix_en, 0);
    chk("h_after_1clk", a_h, 0);
    @(negedge clk);
    chk("pix_en_2", a_pix_en, 1);
    chk("h_after_2clk", a_h, 1);
    @(negedge clk);
    chk("pix_en_3", a_pix_en, 0);

    // First line wrap
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      found = a_ls;
    end
    chk("reach_line1", found, 1);
    chk("line1_h", a_h, 0);
    chk("line1_v", a_v, 1);

    // Measure one full line: period, max h, bright and hsync windows
    cyc = 0; hmax = 0; br_clk = 0; hs_clk = 0;
    br_first = 9999; br_last = -1; hs_first = 9999; hs_last = -1;
    do begin
      if (int'(a_h) > hmax) hmax = int'(a_h);
      if (a_bright) begin
        br_clk++;
        if (int'(a_h) < br_first) br_first = int'(a_h);
        if (int'(a_h) > br_last)  br_last  = int'(a_h);
      end
      if (!a_hs) begin
        hs_clk++;
        if (int'(a_h) < hs_first) hs_first = int'(a_h);
        if (int'(a_h) > hs_last)  hs_last  = int'(a_h);
      end
      @(negedge clk);
      cyc++;
    end while (!a_ls && cyc < 2000);
    chk("line_period", cyc, 1600);
    chk("h_max", hmax, 799);
    chk("line2_v", a_v, 2);
    chk("bright_clk", br_clk, 1280);
    chk("bright_first", br_first, 0);
    chk("bright_last", br_last, 639);
    chk("hsync_clk", hs_clk, 192);
    chk("hsync_first", hs_first, 656);
    chk("hsync_last", hs_last, 751);

    // Look-ahead across line end and visible edge
    wait_a(798, 5, 12000, found);
    chk("reach_798_5", found, 1);
    chk("la_798_x", a_fx, 0);
    chk("la_798_y", a_fy, 6);
    chk("la_798_valid", a_fv, 1);
    @(negedge clk);
    chk("la_798_hold_x", a_fx, 0);
    wait_a(799, 5, 4, found);
    chk("reach_799_5", found, 1);
    chk("la_799_x", a_fx, 1);
    chk("la_799_y", a_fy, 6);
    wait_a(638, 6, 4000, found);
    chk("reach_638_6", found, 1);
    chk("la_638_x", a_fx, 640);
    chk("la_638_y", a_fy, 6);
    chk("la_638_valid", a_fv, 0);
    chk("bright_638", a_bright, 1);

    // Mid-frame reset
    wait_a(300, 7, 4000, found);
    chk("reach_300_7", found, 1);
    clear_a = 1'b0;
    #1;
    chk("mrst_h", a_h, 0);
    chk("mrst_v", a_v, 0);
    chk("mrst_frame_start", a_fs, 1);
    repeat (3) @(negedge clk);
    chk("mrst_hold_h", a_h, 0);
    chk("mrst_hold_pix_en", a_pix_en, 1);
    chk("mrst_hold_fetch_x", a_fx, 2);
    chk("mrst_hold_hsync", a_hs, 1);
    clear_a = 1'b1;
    #1;
    chk("mrel_frame_start", a_fs, 1);
    chk("mrel_h", a_h, 0);
    chk("mrel_v", a_v, 0);
    chk("mrel_frame_count", a_fc, 0);
    @(negedge clk);
    chk("mrel_fs_width", a_fs, 0);
    @(negedge clk);
    chk("mrel_h_next", a_h, 1);

    // Small instance: two whole frames from a fresh reset
    clear_b = 1'b0;
    repeat (2) @(negedge clk);
    clear_b = 1'b1;
    b_pe0 = 0; b_hs_n = 0; b_hs_min = 99; b_hs_max = -1;
    b_vs_n = 0; b_vs_min = 99; b_vs_max = -1;
    b_fs_n = 0; b_fs_idx = -1; b_vb_n = 0; b_vb_v = -1; b_ls_n = 0; b_fc_84 = -1;
    b_f10_x = -1; b_f10_y = -1; b_f10_v = -1; b_f11_x = -1; b_f11_y = -1;
    b_br_7 = -1; b_br_8 = -1;
    for (int i = 0; i < 168; i++) begin
      if (!b_pix_en) b_pe0++;
      if (b_hs) begin
        b_hs_n++;
        if (int'(b_h) < b_hs_min) b_hs_min = int'(b_h);
        if (int'(b_h) > b_hs_max) b_hs_max = int'(b_h);
      end
      if (b_vs) begin
        b_vs_n++;
        if (int'(b_v) < b_vs_min) b_vs_min = int'(b_v);
        if (int'(b_v) > b_vs_max) b_vs_max = int'(b_v);
      end
      if (b_fs) begin
        b_fs_n++;
        b_fs_idx = i;
      end
      if (b_vb) begin
        b_vb_n++;
        b_vb_v = int'(b_v);
      end
      if (b_ls) b_ls_n++;
      if (i == 84) b_fc_84 = int'(b_fc);
      if (b_h == 4'd10 && b_v == 4'd6) begin
        b_f10_x = int'(b_fx); b_f10_y = int'(b_fy); b_f10_v = int'(b_fv);
      end
      if (b_h == 4'd11 && b_v == 4'd6) begin
        b_f11_x = int'(b_fx); b_f11_y = int'(b_fy);
      end
      if (b_h == 4'd7 && b_v == 4'd3) b_br_7 = int'(b_bright);
      if (b_h == 4'd8 && b_v == 4'd3) b_br_8 = int'(b_bright);
      @(negedge clk);
    end
    chk("b_pix_en_low", b_pe0, 0);
    chk("b_hsync_n", b_hs_n, 28);
    chk("b_hsync_min", b_hs_min, 9);
    chk("b_hsync_max", b_hs_max, 10);
    chk("b_vsync_n", b_vs_n, 24);
    chk("b_vsync_min", b_vs_min, 5);
    chk("b_vsync_max", b_vs_max, 5);
    chk("b_frame_start_n", b_fs_n, 2);
    chk("b_frame_period", b_fs_idx, 84);
    chk("b_vblank_n", b_vb_n, 2);
    chk("b_vblank_v", b_vb_v, 4);
    chk("b_line_start_n", b_ls_n, 14);
    chk("b_frame_count_1", b_fc_84, 1);
    chk("b_frame_count_2", b_fc, 2);
    chk("b_frame_start_168", b_fs, 1);
    chk("b_la_10_x", b_f10_x, 0);
    chk("b_la_10_y", b_f10_y, 0);
    chk("b_la_10_valid", b_f10_v, 1);
    chk("b_la_11_x", b_f11_x, 1);
    chk("b_la_11_y", b_f11_y, 0);
    chk("b_bright_7", b_br_7, 1);
    chk("b_bright_8", b_br_8, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA timing controller.
- Generates sync, blanking, pixel coordinates and frame/line event strobes from the 50 MHz system clock.
- Replaces the derived 25 MHz clock with a single-cycle pixel-enable strobe; the whole design stays in one clock domain.
- Adds a look-ahead fetch coordinate so the downstream frame-buffer/sprite reader can issue reads LOOKAHEAD pixels early.

Parameters:
- H_DISP, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_PW, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_DISP, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_PW, 2, vsync pulse width (lines)
- V_BP, 29, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level (0 = active-low)
- CLK_DIV, 2, clk_50MHz cycles per pixel (>=1)
- LOOKAHEAD, 2, fetch-coordinate lead in pixels (0 <= LOOKAHEAD < H_TOTAL)
- COUNTER_BITS, 10, width of the coordinate counters
- Derived constraints: H_TOTAL = H_DISP+H_FP+H_PW+H_BP and V_TOTAL = V_DISP+V_FP+V_PW+V_BP, both <= 2^COUNTER_BITS.

Ports:
- clk_50MHz  in  1  system clock
- clear  in  1  asynchronous active-low reset
- pix_en  out  1  high for the first clk cycle of each pixel period
- h_count  out  COUNTER_BITS  current pixel column, 0..H_TOTAL-1
- v_count  out  COUNTER_BITS  current line, 0..V_TOTAL-1
- h_sync  out  1  horizontal sync, H_POL polarity
- v_sync  out  1  vertical sync, V_POL polarity
- bright  out  1  current position is inside the visible area
- line_start  out  1  pulse at h_count==0
- frame_start  out  1  pulse at h_count==0 and v_count==0
- vblank_start  out  1  pulse at h_count==0 and v_count==V_DISP
- frame_count  out  8  frames completed, wraps at 255
- fetch_x  out  COUNTER_BITS  column LOOKAHEAD pixels ahead of h_count
- fetch_y  out  COUNTER_BITS  line of the look-ahead position
- fetch_valid  out  1  look-ahead position is visible

Behaviour:
- Reset (clear low, asynchronous): div_cnt=0, h_count=0, v_count=0, bright=1, h_sync=!H_POL, v_sync=!V_POL, frame_count=0, pix_en=1, line_start=1, frame_start=1, vblank_start=0. The look-ahead position resets to the position LOOKAHEAD pixels after (0,0); fetch_valid reflects that position.
- Divider:
  - div_cnt counts 0..CLK_DIV-1, then wraps.
  - pix_en = (div_cnt==0).
  - With CLK_DIV=1, pix_en is constantly 1.
- Advance: on the clock edge where div_cnt==CLK_DIV-1, the position advances one pixel. All other outputs update on the same edge and hold for the full pixel period.
- Horizontal wrap: h_count wraps H_TOTAL-1 -> 0. On that wrap, v_count increments; v_count wraps V_TOTAL-1 -> 0.
- Frame counter: frame_count increments on the edge where (H_TOTAL-1, V_TOTAL-1) -> (0,0). It wraps 255 -> 0.
- bright: 1 iff h_count < H_DISP and v_count < V_DISP.
- h_sync: active iff H_DISP+H_FP <= h_count < H_DISP+H_FP+H_PW.
- v_sync:
  - Active iff V_DISP+V_FP <= v_count < V_DISP+V_FP+V_PW, over whole lines.
  - It changes only on the edge where h_count becomes 0.
- Registered decodes: sync and bright are registered decodes of the next position. They are never combinational from the counters, so they are aligned exactly with h_count/v_count and glitch-free.
- Strobes:
  - line_start, frame_start and vblank_start are high only while pix_en=1 in the qualifying pixel period, i.e. one clk cycle wide.
  - frame_start implies line_start.
- Look-ahead:
  - A second position counter (fetch_x, fetch_y) advances on the same edge as h_count.
  - Invariant: linear(fetch) = (linear(h,v) + LOOKAHEAD) mod (H_TOTAL*V_TOTAL).
  - fetch_y wraps into the next line and the next frame exactly as v_count does.
  - fetch_valid = fetch_x < H_DISP and fetch_y < V_DISP.
  - LOOKAHEAD=0 makes fetch_* equal to h_count/v_count, and fetch_valid equal to bright.
- Reset mid-frame: all state returns to the reset values immediately. The first pixel period after release is (0,0), with frame_start high in the first cycle.
- Line and frame periods: no counter ever reaches H_TOTAL or V_TOTAL. Line period = H_TOTAL*CLK_DIV clk cycles; frame period = H_TOTAL*V_TOTAL*CLK_DIV clk cycles.

Test Plan:
- Reset and count-out: release clear, defaults -> pix_en pattern 1,0,1,0; h_count reaches 799 then 0; v_count increments at the same edge; line period is exactly 1600 clk.
- hsync/bright window: sample over a line -> bright high for h 0..639; h_sync low exactly for h 656..751 (96 px = 192 clk); high elsewhere.
- vsync and frame: run two frames -> v_sync low for v 490..491 only; vblank_start at v 480; frame_start every 833,600 clk; frame_count goes 0->1->2.
- Look-ahead wrap: LOOKAHEAD=2 -> at h=798,v=5, fetch=(0,6) and fetch_valid=1; at h=638, fetch=(640,v) and fetch_valid=0; at (799,520), fetch=(1,0).
- Mid-frame reset: assert clear at h=300,v=200 for 3 clk -> outputs equal the reset values during clear; after release, frame_start=1 and h=0,v=0; frame_count=0.
- Parametric: CLK_DIV=1, H_POL=1, V_POL=1, 8x4 timing (H_DISP=8,H_FP=1,H_PW=2,H_BP=1; V_DISP=4,V_FP=1,V_PW=1,V_BP=1) -> pix_en always 1; h_sync high only at h 9..10; v_sync high only at v 5; frame period 84 clk.
